pri_encoder: RTL and testbench

- Registered N-to-log2(N) priority encoder with enable.
- Reports the index of the highest-numbered asserted bit of `din_vec` on `addr_vec`, and flags a valid result on `oe`.
- Used as a request-to-address arbiter front end; default configuration is 8 inputs to a 3-bit address.

---
 rtl/pri_encoder.sv | 57 +++++
 tb/tb_pri_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pri_encoder.sv
// Registered priority encoder: reports the index of the highest set request
// bit one clock after sampling, with a valid flag and a zero address when idle.
module pri_encoder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [WIDTH-1:0]  din_vec,
  output logic              oe,
  output logic [ADDR_W-1:0] addr_vec
);

  // Elaboration-time parameter sanity checks
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("pri_encoder: WIDTH must be at least 2");
    end
    if (ADDR_W != $clog2(WIDTH)) begin : g_bad_addr_w
      $error("pri_encoder: ADDR_W must equal ceil(log2(WIDTH))");
    end
  endgenerate

  logic              oe_d;
  logic              oe_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

  // Ascending scan: a later (higher) set bit overrides any lower one
  always_comb begin
    oe_d   = 1'b0;
    addr_d = '0;
    if (ena) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (din_vec[i]) begin
          oe_d   = 1'b1;
          addr_d = ADDR_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      oe_q   <= oe_d;
      addr_q <= addr_d;
    end
  end

  assign oe       = oe_q;
  assign addr_vec = addr_q;

endmodule

// File: tb/tb_pri_encoder.sv
// Self-checking bench for pri_encoder: a log2-style reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_pri_encoder;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 3;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic              ena   = 1'b0;
  logic [WIDTH-1:0]  din_vec = '0;
  logic              oe;
  logic [ADDR_W-1:0] addr_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic              m_oe   = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;

  pri_encoder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .din_vec  (din_vec),
    .oe       (oe),
    .addr_vec (addr_vec)
  );

  always #5 clk = ~clk;

  // floor(log2(v)) by repeated halving; -1 when v is zero
  function automatic int msb_index(input logic [WIDTH-1:0] v);
    int idx;
    logic [WIDTH-1:0] t;
    idx = -1;
    t   = v;
    while (t != '0) begin
      t = t >> 1;
      idx++;
    end
    return idx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_oe   <= 1'b0;
      m_addr <= '0;
    end else begin
      int k;
      k = ena ? msb_index(din_vec) : -1;
      m_oe   <= (k >= 0);
      m_addr <= (k >= 0) ? ADDR_W'(k) : '0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("model_oe", 32'(oe), 32'(m_oe));
    check("model_addr", 32'(addr_vec), 32'(m_addr));
  end

  task automatic apply(input logic e, input logic [WIDTH-1:0] d);
    @(negedge clk);
    ena     = e;
    din_vec = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic eo, input logic [ADDR_W-1:0] ea);
    check({name, "_oe"}, 32'(oe), 32'(eo));
    check({name, "_addr"}, 32'(addr_vec), 32'(ea));
    check({name, "_model"}, {31'(m_addr), m_oe}, {31'(ea), eo});
  endtask

  logic [WIDTH-1:0] prio_vec [4] = '{8'b0000_0011, 8'b0101_0000, 8'hFF, 8'b1000_0001};
  logic [ADDR_W-1:0] prio_exp [4] = '{3'd1, 3'd6, 3'd7, 3'd7};

  initial begin
    #1;
    rst_n   = 1'b0;
    ena     = 1'b1;
    din_vec = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
      expect_lit("in_reset", 1'b0, 3'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    apply(1'b1, 8'hFF);
    expect_lit("post_release", 1'b1, 3'd7);

    apply(1'b0, 8'h80);
    expect_lit("ena_low", 1'b0, 3'd0);
    apply(1'b1, 8'h80);
    expect_lit("ena_high", 1'b1, 3'd7);

    apply(1'b1, 8'h00);
    expect_lit("zero_in", 1'b0, 3'd0);

    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] oh;
      oh = WIDTH'(1) << i;
      apply(1'b1, oh);
      expect_lit("onehot", 1'b1, ADDR_W'(i));
    end

    for (int i = 0; i < 4; i++) begin
      apply(1'b1, prio_vec[i]);
      expect_lit("priority", 1'b1, prio_exp[i]);
    end

    apply(1'b1, 8'h04);
    expect_lit("b2b_0", 1'b1, 3'd2);
    apply(1'b1, 8'h00);
    expect_lit("b2b_1", 1'b0, 3'd0);
    apply(1'b1, 8'h20);
    expect_lit("b2b_2", 1'b1, 3'd5);

    apply(1'b1, 8'b1010_0110);
    expect_lit("multi", 1'b1, 3'd7);

    // Mid-cycle asynchronous reset with nonzero outputs
    #2;
    rst_n = 1'b0;
    #1;
    expect_lit("async_rst", 1'b0, 3'd0);
    @(negedge clk);
    ena     = 1'b1;
    din_vec = 8'h48;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_lit("rst_release", 1'b1, 3'd6);

    // Simultaneous ena/din change, then random sweep checked by the model
    apply(1'b0, 8'h11);
    expect_lit("both_chg_a", 1'b0, 3'd0);
    apply(1'b1, 8'h11);
    expect_lit("both_chg_b", 1'b1, 3'd4);
    repeat (40) apply(1'($urandom_range(0, 1)), WIDTH'($urandom));

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
